// File: rtl/chacha_block_core.sv
// Iterative ChaCha block engine: one round (or one double round with
// CHACHA_DOUBLE_ROUND_EN defined) per cycle, feed-forward add, valid/ready output.
module chacha_block_core #(
   parameter int ROUNDS = 20
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [255:0] key_i,
   input  logic [95:0]  nonce_i,
   input  logic [31:0]  ctr_in_i,
   input  logic         start_i,
   input  logic         next_i,
   output logic         busy_o,
   output logic         ks_valid_o,
   input  logic         ks_ready_i,
   output logic [511:0] ks_data_o,
   output logic [31:0]  ctr_out_o,
   output logic         ctr_wrap_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

`ifdef CHACHA_DOUBLE_ROUND_EN
   localparam int NCYC = ROUNDS / 2;
`else
   localparam int NCYC = ROUNDS;
`endif

   localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

   function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                       input logic [31:0] c_in, input logic [31:0] d_in);
      logic [31:0] a, b, c, d;
      a = a_in; b = b_in; c = c_in; d = d_in;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {a, b, c, d};
   endfunction

   // Diagonal layer rotates the b/c/d row indices by 1/2/3 columns.
   function automatic logic [511:0] layer(input logic [511:0] s, input logic diag);
      logic [31:0] w [16];
      logic [1:0]  qb;
      logic [3:0]  ia, ib, ic, id;
      logic [511:0] r;
      for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
      for (int q = 0; q < 4; q++) begin
         qb = 2'(q);
         ia = {2'b00, qb};
         ib = {2'b01, qb + {1'b0, diag}};
         ic = {2'b10, qb + {diag, 1'b0}};
         id = {2'b11, qb + {diag, diag}};
         {w[ia], w[ib], w[ic], w[id]} = qr(w[ia], w[ib], w[ic], w[id]);
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   function automatic logic [511:0] init_state(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
      return {n, c, k, SIGMA};
   endfunction

   logic [1:0]   state_q, state_d;
   logic [4:0]   rnd_q, rnd_d;
   logic [255:0] key_q, key_d;
   logic [95:0]  nonce_q, nonce_d;
   logic [31:0]  ctr_q, ctr_d;
   logic [511:0] ks_data_q, ks_data_d;
   logic [31:0]  ctr_out_q, ctr_out_d;
   logic         wrap_q, wrap_d;
   logic [511:0] work_q, work_d;
   logic [511:0] round_out, orig, ff;

`ifdef CHACHA_DOUBLE_ROUND_EN
   assign round_out = layer(layer(work_q, 1'b0), 1'b1);
`else
   assign round_out = layer(work_q, rnd_q[0]);
`endif

   // Stored key/nonce/counter are unchanged until the handshake, so the input state is rebuilt here.
   assign orig = init_state(key_q, nonce_q, ctr_q);

   always_comb begin
      ff = '0;
      for (int i = 0; i < 16; i++) ff[32*i +: 32] = work_q[32*i +: 32] + orig[32*i +: 32];
   end

   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      key_d     = key_q;
      nonce_d   = nonce_q;
      ctr_d     = ctr_q;
      ks_data_d = ks_data_q;
      ctr_out_d = ctr_out_q;
      wrap_d    = 1'b0;
      work_d    = work_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               key_d   = key_i;
               nonce_d = nonce_i;
               ctr_d   = ctr_in_i;
               work_d  = init_state(key_i, nonce_i, ctr_in_i);
               rnd_d   = '0;
               state_d = S_ROUND;
            end else if (next_i) begin
               work_d  = orig;
               rnd_d   = '0;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            work_d = round_out;
            if (rnd_q == 5'(NCYC - 1)) state_d = S_FINAL;
            else rnd_d = rnd_q + 5'd1;
         end
         S_FINAL: begin
            ks_data_d = ff;
            ctr_out_d = ctr_q;
            state_d   = S_HOLD;
         end
         S_HOLD: begin
            if (ks_ready_i) begin
               ctr_d   = ctr_q + 32'd1;
               wrap_d  = (ctr_q == 32'hFFFF_FFFF);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rnd_q     <= '0;
         key_q     <= '0;
         nonce_q   <= '0;
         ctr_q     <= '0;
         ks_data_q <= '0;
         ctr_out_q <= '0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         key_q     <= key_d;
         nonce_q   <= nonce_d;
         ctr_q     <= ctr_d;
         ks_data_q <= ks_data_d;
         ctr_out_q <= ctr_out_d;
         wrap_q    <= wrap_d;
      end
   end

   // Working state is pure datapath; it is always rebuilt before use.
   always_ff @(posedge clk_i) begin
      work_q <= work_d;
   end

   assign busy_o     = (state_q != S_IDLE);
   assign ks_valid_o = (state_q == S_HOLD);
   assign ks_data_o  = ks_data_q;
   assign ctr_out_o  = ctr_out_q;
   assign ctr_wrap_o = wrap_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: vector table, scoreboard of expected
// blocks from an independent ChaCha model, and hand-written corner sequences.
module tb_chacha_block_core;
   localparam int ROUNDS = 20;
`ifdef CHACHA_DOUBLE_ROUND_EN
   localparam int LAT = ROUNDS / 2 + 2;
`else
   localparam int LAT = ROUNDS + 2;
`endif
   localparam int M_START = 0;
   localparam int M_NEXT  = 1;
   localparam int M_BOTH  = 2;

   logic         clk, rst;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  ctr_in;
   logic         start, next, ks_ready;
   logic         busy, ks_valid, ctr_wrap;
   logic [511:0] ks_data;
   logic [31:0]  ctr_out;

   chacha_block_core #(.ROUNDS(ROUNDS)) dut (
      .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .ctr_in_i(ctr_in),
      .start_i(start), .next_i(next), .busy_o(busy), .ks_valid_o(ks_valid),
      .ks_ready_i(ks_ready), .ks_data_o(ks_data), .ctr_out_o(ctr_out), .ctr_wrap_o(ctr_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [511:0] data; logic [31:0] ctr; } exp_t;
   exp_t sbq[$];

   typedef struct {
      int           mode;
      logic [255:0] key;
      logic [95:0]  nonce;
      logic [31:0]  ctr;
      logic         use_const;
      logic [511:0] exp_data;
      logic [31:0]  exp_ctr;
   } vec_t;
   vec_t tv[4];

   // Bench-side copy of the stored key/nonce/counter.
   logic [255:0] mk;
   logic [95:0]  mn;
   logic [31:0]  mc;

   logic [255:0] rfc_key;
   localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;
   localparam logic [511:0] RFC_BLOCK = {
      32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
      32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
      32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
      32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] mqr(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0);
      logic [31:0] a, b, c, d;
      a = a0; b = b0; c = c0; d = d0;
      a += b; d = rotl(d ^ a, 16);
      c += d; b = rotl(b ^ c, 12);
      a += b; d = rotl(d ^ a, 8);
      c += d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
      logic [31:0] x [16];
      logic [31:0] in0 [16];
      logic [511:0] o;
      in0[0] = 32'h61707865; in0[1] = 32'h3320646e; in0[2] = 32'h79622d32; in0[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) in0[4 + i] = k[32*i +: 32];
      in0[12] = c;
      for (int i = 0; i < 3; i++) in0[13 + i] = n[32*i +: 32];
      for (int i = 0; i < 16; i++) x[i] = in0[i];
      for (int r = 0; r < ROUNDS; r += 2) begin
         {x[0], x[4], x[8],  x[12]} = mqr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = mqr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = mqr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = mqr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = mqr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = mqr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = mqr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = mqr(x[3], x[4], x[9],  x[14]);
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + in0[i];
      return o;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic st, input logic nx, input logic [255:0] k,
                            input logic [95:0] n, input logic [31:0] c, output int lat);
      @(negedge clk);
      start = st; next = nx; key = k; nonce = n; ctr_in = c;
      @(posedge clk); #1;
      start = 1'b0; next = 1'b0;
      lat = 1;
      while (!ks_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL %s_scoreboard actual=empty required=entry", tag);
      end else begin
         checks--;
         e = sbq.pop_front();
         chk({tag, "_data"}, ks_data, e.data);
         chk({tag, "_ctr"}, 512'(ctr_out), 512'(e.ctr));
      end
   endtask

   task automatic accept(input string tag, input logic exp_wrap);
      ks_ready = 1'b1;
      @(posedge clk); #1;
      ks_ready = 1'b0;
      mc = mc + 32'd1;
      chk({tag, "_valid_drop"}, 512'(ks_valid), 512'(0));
      chk({tag, "_wrap"}, 512'(ctr_wrap), 512'(exp_wrap));
      @(posedge clk); #1;
      chk({tag, "_wrap_end"}, 512'(ctr_wrap), 512'(0));
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, 512'(busy), 512'(0));
      chk({tag, "_valid"}, 512'(ks_valid), 512'(0));
      chk({tag, "_data"}, ks_data, 512'(0));
      chk({tag, "_ctr"}, 512'(ctr_out), 512'(0));
      chk({tag, "_wrap"}, 512'(ctr_wrap), 512'(0));
   endtask

   initial begin
      exp_t e;
      int   lat;
      string nm;

      rst = 1'b1; start = 1'b0; next = 1'b0; ks_ready = 1'b0;
      key = '0; nonce = '0; ctr_in = '0;
      mk = '0; mn = '0; mc = '0;
      for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);

      tv[0] = '{M_START, rfc_key, RFC_NONCE, 32'd1, 1'b1, RFC_BLOCK, 32'd1};
      tv[1] = '{M_NEXT, '0, '0, '0, 1'b0, '0, 32'd2};
      tv[2] = '{M_BOTH,
                256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_fedcba98_76543210,
                96'hcafef00d_13579bdf_2468ace0, 32'h89abcdef, 1'b0, '0, 32'h89abcdef};
      tv[3] = '{M_NEXT, '0, '0, '0, 1'b0, '0, 32'h89abcdf0};

      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         nm = $sformatf("vec%0d", i);
         if (tv[i].mode != M_NEXT) begin
            mk = tv[i].key; mn = tv[i].nonce; mc = tv[i].ctr;
         end
         e.data = tv[i].use_const ? tv[i].exp_data : chacha_ref(mk, mn, mc);
         e.ctr  = tv[i].exp_ctr;
         sbq.push_back(e);
         drive_req(tv[i].mode != M_NEXT, tv[i].mode != M_START,
                   tv[i].key, tv[i].nonce, tv[i].ctr, lat);
         chk({nm, "_latency"}, 512'(lat), 512'(LAT));
         chk({nm, "_busy"}, 512'(busy), 512'(1));
         pop_check(nm);
         accept(nm, 1'b0);
      end

      // Back-pressure: block must hold while start pulses are ignored.
      mk = rfc_key; mn = RFC_NONCE; mc = 32'd1;
      e.data = RFC_BLOCK; e.ctr = 32'd1;
      drive_req(1'b1, 1'b0, rfc_key, RFC_NONCE, 32'd1, lat);
      chk("bp_latency", 512'(lat), 512'(LAT));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         start = 1'b1; key = ~rfc_key; nonce = 96'h1; ctr_in = 32'h55;
         @(posedge clk); #1;
         start = 1'b0;
         chk($sformatf("bp%0d_valid", c), 512'(ks_valid), 512'(1));
         chk($sformatf("bp%0d_busy", c), 512'(busy), 512'(1));
         chk($sformatf("bp%0d_data", c), ks_data, e.data);
         chk($sformatf("bp%0d_ctr", c), 512'(ctr_out), 512'(e.ctr));
      end
      accept("bp", 1'b0);
      e.data = chacha_ref(mk, mn, mc); e.ctr = 32'd2;
      sbq.push_back(e);
      drive_req(1'b0, 1'b1, '0, '0, '0, lat);
      chk("bp_next_latency", 512'(lat), 512'(LAT));
      pop_check("bp_next");
      accept("bp_next", 1'b0);

      // Counter wrap.
      mk = tv[2].key; mn = tv[2].nonce; mc = 32'hFFFF_FFFF;
      e.data = chacha_ref(mk, mn, mc); e.ctr = 32'hFFFF_FFFF;
      sbq.push_back(e);
      drive_req(1'b1, 1'b0, mk, mn, mc, lat);
      pop_check("wrap_first");
      accept("wrap_first", 1'b1);
      e.data = chacha_ref(mk, mn, mc); e.ctr = 32'd0;
      sbq.push_back(e);
      drive_req(1'b0, 1'b1, '0, '0, '0, lat);
      chk("wrap_second_latency", 512'(lat), 512'(LAT));
      pop_check("wrap_second");
      accept("wrap_second", 1'b0);

      // Reset five cycles into ROUND, then next runs on all-zero stored state.
      @(negedge clk);
      start = 1'b1; key = tv[2].key; nonce = tv[2].nonce; ctr_in = 32'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("mid_busy", 512'(busy), 512'(1));
      rst = 1'b1;
      #1;
      check_zero_outputs("rst_async");
      @(posedge clk); #1;
      check_zero_outputs("rst_held");
      @(negedge clk); rst = 1'b0;
      mk = '0; mn = '0; mc = '0;
      e.data = chacha_ref('0, '0, '0); e.ctr = 32'd0;
      sbq.push_back(e);
      drive_req(1'b0, 1'b1, '0, '0, '0, lat);
      chk("post_rst_latency", 512'(lat), 512'(LAT));
      pop_check("post_rst");
      accept("post_rst", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
